// File: rtl/time_entry_if.sv
// Keypad-to-timer-chain bundle for the MM:SS time entry loader.
//   key_valid/key_code : keypad strobe and code (digit, CLEAR, START)
//   timer_done         : counter chain reached 00:00 while running
//   loadn              : active-low parallel load into the counter chain
//   min_tens..sec_ones : buffered BCD digits (load data and display)
//   running            : chain count enable
//   abort / err        : one-cycle pulses for cancelled run / rejected key
// slave = loader side, master = keypad/timer side.
interface time_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       timer_done;
    logic       loadn;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       abort;
    logic       err;

    modport slave (
        input  key_valid, key_code, timer_done,
        output loadn, min_tens, min_ones, sec_tens, sec_ones, running, abort, err
    );

    modport master (
        output key_valid, key_code, timer_done,
        input  loadn, min_tens, min_ones, sec_tens, sec_ones, running, abort, err
    );
endinterface

// File: rtl/time_entry_loader.sv
// Keypad-side writer for the microwave MM:SS down-counter chain.
// Shifts BCD digit keys into a 4-digit buffer, validates it on START, issues a
// one-cycle active-low load to the chain, then tracks the run until the chain
// reports done or the user cancels with CLEAR.
// Ports:
//   clock : system clock, rising edge
//   clr   : asynchronous active-high reset
//   bus   : time_entry_if.slave (key strobe/code, timer_done in; load, digits,
//           running, abort, err out; all outputs registered)
module time_entry_loader #(
    parameter logic [3:0]  KEY_CLEAR    = 4'd10,
    parameter logic [3:0]  KEY_START    = 4'd11,
    parameter int unsigned MAX_DIGITS   = 4,
    parameter logic [3:0]  SEC_TENS_MAX = 4'd5
) (
    input  logic          clock,
    input  logic          clr,
    time_entry_if.slave   bus
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned BUF_W = 4 * DIG_W;
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;     // {min_tens, min_ones, sec_tens, sec_ones}
    logic [CNT_W-1:0]   count_q, count_d;
    logic               loadn_q, loadn_d;
    logic               running_q, running_d;
    logic               abort_q, abort_d;
    logic               err_q, err_d;

    logic               is_digit, is_clear, is_start;

    // Key decode; codes 12-15 match nothing and fall through untouched.
    assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign is_start = bus.key_valid && (bus.key_code == KEY_START);

    // State and output registers
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            count_q   <= '0;
            loadn_q   <= 1'b1;
            running_q <= 1'b0;
            abort_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            loadn_q   <= loadn_d;
            running_q <= running_d;
            abort_q   <= abort_d;
            err_q     <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        count_d   = count_q;
        loadn_d   = 1'b1;
        running_d = 1'b0;
        abort_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE, ENTRY: begin
                if (is_digit) begin
                    if (count_q < CNT_W'(MAX_DIGITS)) begin
                        buf_d   = {buf_q[BUF_W-DIG_W-1:0], bus.key_code};
                        count_d = count_q + CNT_W'(1);
                        state_d = ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_clear) begin
                    buf_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (is_start) begin
                    // Empty buffer or seconds-tens above 5 cannot be loaded.
                    if (state_q == IDLE) begin
                        err_d = 1'b1;
                    end else if (buf_q[2*DIG_W-1:DIG_W] > SEC_TENS_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        loadn_d = 1'b0;
                        state_d = LOAD;
                    end
                end
            end

            // Single load cycle; keys are ignored here.
            LOAD: begin
                running_d = 1'b1;
                state_d   = RUN;
            end

            // CLEAR takes priority over timer_done so a cancel is always reported.
            RUN: begin
                if (is_clear) begin
                    abort_d = 1'b1;
                    buf_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (bus.timer_done) begin
                    buf_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    running_d = 1'b1;
                end
            end

            default: begin
                buf_d   = '0;
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.loadn    = loadn_q;
    assign bus.running  = running_q;
    assign bus.abort    = abort_q;
    assign bus.err      = err_q;
    assign bus.min_tens = buf_q[4*DIG_W-1:3*DIG_W];
    assign bus.min_ones = buf_q[3*DIG_W-1:2*DIG_W];
    assign bus.sec_tens = buf_q[2*DIG_W-1:DIG_W];
    assign bus.sec_ones = buf_q[DIG_W-1:0];

endmodule
